// File: rtl/digest_reader_pkg.sv
// Shared SHA256 digest readback constants and helpers.
// Used by digest_reader; byte swap helper serves DIGEST_BSWAP_EN builds.
package digest_reader_pkg;

    localparam int WORD = 32;
    localparam int DIGEST_WORDS = 8;
    localparam int DR_IDX_W = 3;

    localparam logic [0:0] DR_IDLE = 1'b0;
    localparam logic [0:0] DR_SEND = 1'b1;

    function automatic logic [WORD-1:0] bswap(input logic [WORD-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/digest_reader.sv
// Snapshots the eight SHA256 hash words and streams them out, hash0 first.
// Define DIGEST_BSWAP_EN to byte-reverse each word for little-endian hosts.
module digest_reader
    import digest_reader_pkg::*;
#(
    parameter int NUM_WORDS = DIGEST_WORDS,
    parameter int WORD_W    = WORD
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WORD_W-1:0]   hash0,
    input  logic [WORD_W-1:0]   hash1,
    input  logic [WORD_W-1:0]   hash2,
    input  logic [WORD_W-1:0]   hash3,
    input  logic [WORD_W-1:0]   hash4,
    input  logic [WORD_W-1:0]   hash5,
    input  logic [WORD_W-1:0]   hash6,
    input  logic [WORD_W-1:0]   hash7,
    input  logic                digest_valid,
    output logic                capture_ready,
    output logic [WORD_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [DR_IDX_W-1:0] m_index,
    output logic                overrun
);

    generate
        if (NUM_WORDS != 8 || WORD_W != 32) begin : g_bad_cfg
            $error("digest_reader supports only NUM_WORDS=8, WORD_W=32");
        end
    endgenerate

    localparam logic [DR_IDX_W-1:0] LAST_IDX = DR_IDX_W'(NUM_WORDS - 1);

    logic [0:0]          state;
    logic [DR_IDX_W-1:0] idx;
    logic [WORD_W-1:0]   shadow  [NUM_WORDS];
    logic [WORD_W-1:0]   hash_in [NUM_WORDS];
    logic [WORD_W-1:0]   word;

    always_comb begin
        hash_in[0] = hash0;
        hash_in[1] = hash1;
        hash_in[2] = hash2;
        hash_in[3] = hash3;
        hash_in[4] = hash4;
        hash_in[5] = hash5;
        hash_in[6] = hash6;
        hash_in[7] = hash7;
    end

    // Captures are only taken in IDLE; any request seen in SEND is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DR_IDLE;
            idx     <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == DR_IDLE) begin
            if (digest_valid) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    shadow[i] <= hash_in[i];
                end
                idx     <= '0;
                overrun <= 1'b0;
                state   <= DR_SEND;
            end
        end else begin
            if (digest_valid) begin
                overrun <= 1'b1;
            end
            if (m_ready) begin
                if (idx == LAST_IDX) begin
                    idx   <= '0;
                    state <= DR_IDLE;
                end else begin
                    idx <= idx + DR_IDX_W'(1);
                end
            end
        end
    end

    assign word = shadow[idx];

`ifdef DIGEST_BSWAP_EN
    assign m_data = bswap(word);
`else
    assign m_data = word;
`endif

    assign capture_ready = (state == DR_IDLE);
    assign m_valid       = (state == DR_SEND);
    assign m_index       = idx;
    assign m_last        = (state == DR_SEND) && (idx == LAST_IDX);

endmodule

// File: tb/tb_digest_reader.sv
// Scoreboard bench for digest_reader: directed "abc" digest streams.
// Expected words are queued at capture and checked by a handshake monitor.
module tb_digest_reader;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [2:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] hash [8];
    logic        digest_valid = 1'b0;
    logic        capture_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [2:0]  m_index;
    logic        overrun;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] abc [8] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    logic        held_v = 1'b0;
    logic [31:0] held_d;
    logic [2:0]  held_i;
    logic        held_l;

    digest_reader dut (
        .clk(clk),
        .resetn(resetn),
        .hash0(hash[0]),
        .hash1(hash[1]),
        .hash2(hash[2]),
        .hash3(hash[3]),
        .hash4(hash[4]),
        .hash5(hash[5]),
        .hash6(hash[6]),
        .hash7(hash[7]),
        .digest_valid(digest_valid),
        .capture_ready(capture_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .m_index(m_index),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef DIGEST_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on each handshake, checks stability under backpressure.
    always @(negedge clk) begin
        if (resetn && m_valid) begin
            if (held_v) begin
                chk("hold_data", m_data, held_d);
                chk("hold_index", 32'(m_index), 32'(held_i));
                chk("hold_last", 32'(m_last), 32'(held_l));
            end
            if (m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected none", m_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_data", m_data, e.d);
                    chk("word_index", 32'(m_index), 32'(e.idx));
                    chk("word_last", 32'(m_last), 32'(e.last));
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = m_data;
                held_i = m_index;
                held_l = m_last;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic set_hash(input logic [31:0] v [8]);
        for (int i = 0; i < 8; i++) hash[i] = v[i];
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 8; i++) hash[i] = v;
    endtask

    // Called #1 after a rising edge; returns #1 after the capture edge.
    task automatic capture_abc();
        set_hash(abc);
        digest_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q.push_back('{d: xf(abc[i]), last: (i == 7), idx: 3'(i)});
        end
        @(posedge clk);
        #1;
        digest_valid = 1'b0;
    endtask

    task automatic wait_index(input logic [2:0] target);
        int n;
        n = 0;
        while (m_index !== target && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_index !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_index: got %0d expected %0d", m_index, target);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_valid || q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_idle", 32'(m_valid), 32'd0);
        chk("drain_queue", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        set_all(32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_cap_ready", 32'(capture_ready), 32'd1);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_m_index", 32'(m_index), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'h0);

        // Straight stream with m_ready held high.
        m_ready = 1'b1;
        capture_abc();
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        chk("lat_cap_ready", 32'(capture_ready), 32'd0);
        chk("lat_first", m_data, xf(abc[0]));
        repeat (8) @(posedge clk);
        #1;
        chk("abc_idle_valid", 32'(m_valid), 32'd0);
        chk("abc_idle_ready", 32'(capture_ready), 32'd1);
        chk("abc_queue", 32'(q.size()), 32'd0);

        // Backpressure plus snapshot isolation.
        capture_abc();
        set_all(32'hffffffff);
        for (int k = 0; k < 64 && (m_valid || q.size() != 0); k++) begin
            m_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        drain(4);

        // Dropped captures at index 3 and at the final handshake.
        capture_abc();
        set_all(32'h11111111);
        wait_index(3'd3);
        digest_valid = 1'b1;
        @(posedge clk);
        #1;
        digest_valid = 1'b0;
        chk("ovr_flag_mid", 32'(overrun), 32'd1);
        chk("ovr_index_mid", 32'(m_index), 32'd4);
        wait_index(3'd7);
        chk("ovr_last", 32'(m_last), 32'd1);
        digest_valid = 1'b1;
        @(posedge clk);
        #1;
        digest_valid = 1'b0;
        chk("ovr_dropped_final", 32'(m_valid), 32'd0);
        chk("ovr_flag_final", 32'(overrun), 32'd1);
        chk("ovr_queue", 32'(q.size()), 32'd0);
        capture_abc();
        chk("ovr_cleared", 32'(overrun), 32'd0);
        drain(12);

        // Reset mid-stream at index 5.
        capture_abc();
        wait_index(3'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_index", 32'(m_index), 32'd0);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(capture_ready), 32'd1);
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        capture_abc();
        chk("post_rst_index", 32'(m_index), 32'd0);
`ifdef DIGEST_BSWAP_EN
        chk("post_rst_first", m_data, 32'hbf1678ba);
`else
        chk("post_rst_first", m_data, 32'hba7816bf);
`endif
        drain(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digest_reader.md
Name: digest_reader

Overview:
- Reads out the eight 32-bit intermediate/final hash words produced by the hash accumulator, as a word stream toward the AXI register/readback side of the SHA256 accelerator.
- On a capture request it snapshots all eight words into shadow registers, so the accumulator can start the next message immediately.
- It then emits the snapshot one word per valid/ready handshake, hash0 first.

Parameters:
- NUM_WORDS, 8, number of digest words streamed; fixed at 8 for SHA256, range-checked only.
- WORD_W, 32, width of each word; matches the shared WORD macro.

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- hash0..hash7  input  32 each  live hash words from the accumulator
- digest_valid  input  1  one-cycle capture request; the hash inputs are stable this cycle
- capture_ready  output  1  high when a capture will be accepted (state IDLE)
- m_data  output  32  current digest word
- m_valid  output  1  m_data is valid
- m_ready  input  1  downstream accepts the word
- m_last  output  1  high with the final word (index NUM_WORDS-1)
- m_index  output  3  index of the word on m_data
- overrun  output  1  sticky flag: a capture request was dropped

Behaviour:
- Reset (async assert, sync release): state IDLE; shadow regs 0; m_valid 0; m_last 0; m_index 0; m_data 0; overrun 0; capture_ready 1 after release.
- States:
  - IDLE: capture_ready=1, m_valid=0.
  - SEND: capture_ready=0, m_valid=1.
- IDLE to SEND: digest_valid=1 in cycle N.
  - All eight hash inputs are latched into shadow[0..7] at edge N.
  - m_index := 0; overrun := 0.
  - m_valid=1 with shadow[0] from cycle N+1. Capture-to-first-word latency is 1 cycle.
- In SEND, a handshake is m_valid && m_ready at a rising edge:
  - m_index < 7: m_index increments; m_data shows the next shadow word the following cycle.
  - m_index == 7: return to IDLE; m_valid drops next cycle; m_index := 0.
- Best-case throughput: 8 words in 8 consecutive cycles.
- While m_valid=1 && m_ready=0: m_data, m_index and m_last hold stable (AXI-stream rules). m_valid never drops without a handshake.
- m_last = (state==SEND) && (m_index==NUM_WORDS-1).
- m_data is combinational from shadow[m_index] (muxed). The shadow bank is written only on an accepted capture.
- Dropped captures:
  - digest_valid while in SEND is dropped, including the cycle of the final handshake. overrun := 1.
  - Shadow contents and stream progress are unaffected.
- m_ready in IDLE is ignored.
- Reset mid-stream aborts immediately: m_valid falls asynchronously, and no partial word is re-emitted after release.
- No arithmetic is performed. Word order is fixed: hash0 → index 0 … hash7 → index 7.

Optional Feature:
- Macro: DIGEST_BSWAP_EN.
- Defined: m_data is each shadow word byte-reversed ({b0,b1,b2,b3}), for little-endian host readback. Swapping is combinational on the output path, so latency is unchanged.
- Undefined: m_data is the shadow word unmodified (big-endian, FIPS 180-4 order).

Decomposition:
- sha256types.vh (shared header) gets:
  - the WORD width macro (already present);
  - DIGEST_WORDS = 8;
  - state encodings DR_IDLE=1'b0 and DR_SEND=1'b1;
  - the index-width constant (3).
- No sub-module is warranted. The shadow bank, 8:1 mux, counter and two-state FSM stay flat in one module; byte swap is an inline function/assign.

Test Plan:
- Reset then idle: hold resetn=0 for 3 cycles, then release → m_valid=0, capture_ready=1, overrun=0, m_index=0.
- "abc" digest, m_ready held 1: hash0..7 = ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad; pulse digest_valid → words appear in that order on 8 consecutive cycles starting N+1; m_last only with f20015ad; IDLE at N+9.
- Backpressure: same stimulus, m_ready toggled 1,0,0,1,… → each word holds stable while m_ready=0; the sequence is still complete and in order; no duplicates.
- Snapshot isolation: change the hash inputs to all 0xFFFFFFFF the cycle after capture → the stream still emits the "abc" digest.
- Overrun: pulse digest_valid at m_index=3, and again in the final-handshake cycle → both dropped, overrun=1, stream unaltered. A subsequent accepted capture clears overrun.
- Reset mid-stream at m_index=5 → m_valid=0 immediately; after release, capture_ready=1 and a new capture streams from index 0. With DIGEST_BSWAP_EN defined, the first word reads bf1678ba.
